nbdcache_writeback_unit: RTL and testbench
==========================================

NBDCACHE_WRITEBACK_UNIT -- requirements
Module: nbdcache_writeback_unit

Interface
REQ-001 Parameter TAGLEN, 20, line tag width.
REQ-002 Parameter IDXLEN, 6, set index width.
REQ-003 Parameter PARAMLEN, 3, release permission-parameter width.
REQ-004 Parameter WAYLEN, 8, one-hot way-enable width.
REQ-005 Parameter BEATS, 4, 128-bit beats per 64-byte line.
REQ-006 Parameter DATAW, 128, data beat width.
REQ-007 clock  input  1  sole clock, rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 wb_req_valid / wb_req_ready  input / output  1 / 1  writeback request handshake.
REQ-010 wb_req_tag, wb_req_idx, wb_req_param, wb_req_way_en, wb_req_voluntary  input  TAGLEN / IDXLEN / PARAMLEN / WAYLEN / 1  victim line descriptor.
REQ-011 data_req_valid / data_req_ready  output / input  1 / 1  L1 data-array read handshake.
REQ-012 data_req_way_en, data_req_addr  output  WAYLEN / 12  read way and byte address {idx, beat[1:0], 4'b0}.
REQ-013 data_resp_data  input  DATAW  read data, valid exactly one cycle after a data_req handshake.
REQ-014 release_valid / release_ready  output / input  1 / 1  outbound release-beat handshake.
REQ-015 release_addr, release_param, release_voluntary, release_data, release_last  output  32 / PARAMLEN / 1 / DATAW / 1  release beat; addr = {tag, idx, 6'b0}.
REQ-016 release_ack  input  1  grant-ack pulse for voluntary release (used only under REQ-031).

Function
REQ-017 FSM states IDLE, READ, DRAIN, ACK_WAIT; wb_req_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: wb_req handshake latches tag, idx, param, way_en, voluntary; clears counters; -> READ.
REQ-019 READ: data_req_valid=1, addr beat = read counter rc; rc increments on data_req handshake; after beat BEATS-1 handshake -> DRAIN.
REQ-020 data_req_addr/way_en SHALL stay stable while data_req_valid=1 and data_req_ready=0.
REQ-021 A handshake at cycle t SHALL write data_resp_data at t+1 into 4-entry line buffer slot rc(t); written counter wc increments at t+1.
REQ-022 release_valid=1 whenever send counter sc < wc, in READ or DRAIN; release beats may overlap reads (earliest beat 0 at t+2 after first read handshake).
REQ-023 release_data = buffer[sc]; all release outputs stable while release_valid=1 and release_ready=0.
REQ-024 release_last=1 iff sc = BEATS-1; sc increments on release handshake.
REQ-025 Last-beat handshake: voluntary=0 -> IDLE; voluntary=1 -> IDLE, or ACK_WAIT under REQ-031.
REQ-026 ACK_WAIT: release_ack=1 -> IDLE; release_ack outside ACK_WAIT SHALL be ignored.
REQ-027 Counters 2-bit, wrap 3->0, never exceed BEATS; a new request cannot be accepted in the cycle the final beat sends (ready asserts the following cycle).

Reset
REQ-028 reset_n=0 asynchronously forces IDLE, rc=wc=sc=0, all valids and release_last 0, latched descriptor 0; buffer contents not reset.
REQ-029 Reset mid-line SHALL abandon the line; no beat is issued after reset release until a new wb_req handshake.
REQ-030 After reset, wb_req_ready=1 on the first clock edge with reset_n=1.

Configuration
REQ-031 Macro NBDCACHE_WB_RELEASE_ACK_EN defined: voluntary lines enter ACK_WAIT after last beat; undefined: ACK_WAIT absent, release_ack unused, always -> IDLE.

Structure
REQ-032 Package nbdcache_pkg holds TAGLEN, IDXLEN, PARAMLEN, WAYLEN, BEATS, DATAW and the wb_state_e enum.
REQ-033 Sub-module nbdcache_wb_linebuf: 4x DATAW register file, one write port, one async read port.

Verification
REQ-034 tag=0xABCDE, idx=0x15, way_en=0x04, both readies 1 -> addrs 0x540,0x550,0x560,0x570 consecutive; release_addr=0xABCDE540; last on beat 3; ready back 1 cycle later.
REQ-035 data_req_ready toggling 1,0,1,0 -> addr held when stalled; beat data matches injected 128'h...0/1/2/3 in order.
REQ-036 release_ready=0 for 6 cycles -> reads finish, DRAIN holds beat 0 stable, then 4 beats drain back-to-back.
REQ-037 voluntary=1 with macro -> ACK_WAIT until release_ack pulse, wb_req_ready=0 meanwhile; without macro -> IDLE immediately.
REQ-038 reset_n pulse after beat 1 sent -> all valids 0 asynchronously, wb_req_ready=1 after release, no stray beats.

Source files
------------

// File: rtl/nbdcache_pkg.sv
// Shared constants and FSM state type for the non-blocking D-cache
// writeback unit and its line buffer.
package nbdcache_pkg;

  localparam int TAGLEN   = 20;
  localparam int IDXLEN   = 6;
  localparam int PARAMLEN = 3;
  localparam int WAYLEN   = 8;
  localparam int BEATS    = 4;
  localparam int DATAW    = 128;

  // Width of the beat counters / line-buffer address.
  localparam int BEAT_W   = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    DRAIN    = 2'd2,
    ACK_WAIT = 2'd3
  } wb_state_e;

endpackage

// File: rtl/nbdcache_wb_linebuf.sv
// Four-entry line buffer holding one victim line between the data-array
// read and the outbound release. One synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module nbdcache_wb_linebuf
  import nbdcache_pkg::BEATS, nbdcache_pkg::BEAT_W;
#(
  parameter int DATAW = nbdcache_pkg::DATAW
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [BEAT_W-1:0] wr_addr,
  input  logic [DATAW-1:0]  wr_data,
  input  logic [BEAT_W-1:0] rd_addr,
  output logic [DATAW-1:0]  rd_data
);

  logic [DATAW-1:0] mem [BEATS];

  // Capture one returned data beat into its slot.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nbdcache_writeback_unit.sv
// Writeback unit: accepts a victim-line descriptor, reads the line out of
// the L1 data array beat by beat into a small buffer and streams it out as
// release beats, overlapping the release with the remaining reads.
// Optional feature macro: NBDCACHE_WB_RELEASE_ACK_EN -- when defined,
// voluntary releases wait in ACK_WAIT for a release_ack pulse before the
// unit accepts the next request.
module nbdcache_writeback_unit #(
  parameter int TAGLEN   = nbdcache_pkg::TAGLEN,
  parameter int IDXLEN   = nbdcache_pkg::IDXLEN,
  parameter int PARAMLEN = nbdcache_pkg::PARAMLEN,
  parameter int WAYLEN   = nbdcache_pkg::WAYLEN,
  parameter int BEATS    = nbdcache_pkg::BEATS,
  parameter int DATAW    = nbdcache_pkg::DATAW
) (
  input  logic                clock,
  input  logic                reset_n,
  // writeback request
  input  logic                wb_req_valid,
  output logic                wb_req_ready,
  input  logic [TAGLEN-1:0]   wb_req_tag,
  input  logic [IDXLEN-1:0]   wb_req_idx,
  input  logic [PARAMLEN-1:0] wb_req_param,
  input  logic [WAYLEN-1:0]   wb_req_way_en,
  input  logic                wb_req_voluntary,
  // data-array read
  output logic                data_req_valid,
  input  logic                data_req_ready,
  output logic [WAYLEN-1:0]   data_req_way_en,
  output logic [11:0]         data_req_addr,
  input  logic [DATAW-1:0]    data_resp_data,
  // release beats
  output logic                release_valid,
  input  logic                release_ready,
  output logic [31:0]         release_addr,
  output logic [PARAMLEN-1:0] release_param,
  output logic                release_voluntary,
  output logic [DATAW-1:0]    release_data,
  output logic                release_last,
  input  logic                release_ack
);

  import nbdcache_pkg::*;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  wb_state_e state;

  // rc: next beat to read, wc: beats written to the buffer, sc: next beat to send
  logic [1:0] rc;
  logic [1:0] wc;
  logic [1:0] sc;
  // wc wraps to 0 after the fourth write; wr_full remembers the line is complete
  logic       wr_full;
  // a read handshake last cycle means data_resp_data is valid this cycle
  logic       resp_pending;

  logic [TAGLEN-1:0]   tag_q;
  logic [IDXLEN-1:0]   idx_q;
  logic [PARAMLEN-1:0] param_q;
  logic [WAYLEN-1:0]   way_q;
  logic                vol_q;

  logic active;
  logic data_req_fire;
  logic release_fire;

  assign active        = (state == READ) || (state == DRAIN);
  assign wb_req_ready  = (state == IDLE);

  assign data_req_valid  = (state == READ);
  assign data_req_way_en = way_q;
  assign data_req_addr   = {idx_q, rc, 4'b0000};
  assign data_req_fire   = data_req_valid && data_req_ready;

  // A beat is sendable once it has landed in the buffer.
  assign release_valid     = active && (wr_full || (sc < wc));
  assign release_fire      = release_valid && release_ready;
  assign release_last      = (sc == LAST_BEAT);
  assign release_addr      = {tag_q, idx_q, 6'b000000};
  assign release_param     = param_q;
  assign release_voluntary = vol_q;

`ifndef NBDCACHE_WB_RELEASE_ACK_EN
  logic unused_release_ack;
  assign unused_release_ack = release_ack;
`endif

  nbdcache_wb_linebuf #(
    .DATAW (DATAW)
  ) u_linebuf (
    .clock   (clock),
    .wr_en   (resp_pending),
    .wr_addr (wc),
    .wr_data (data_resp_data),
    .rd_addr (sc),
    .rd_data (release_data)
  );

  // Control FSM: descriptor latch, beat counters and state sequencing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rc           <= 2'd0;
      wc           <= 2'd0;
      sc           <= 2'd0;
      wr_full      <= 1'b0;
      resp_pending <= 1'b0;
      tag_q        <= '0;
      idx_q        <= '0;
      param_q      <= '0;
      way_q        <= '0;
      vol_q        <= 1'b0;
    end else begin
      resp_pending <= data_req_fire;

      if (resp_pending) begin
        wc <= wc + 2'd1;
        if (wc == LAST_BEAT) begin
          wr_full <= 1'b1;
        end
      end

      if (data_req_fire) begin
        rc <= rc + 2'd1;
      end

      if (release_fire) begin
        sc <= sc + 2'd1;
      end

      case (state)
        IDLE: begin
          if (wb_req_valid) begin
            tag_q   <= wb_req_tag;
            idx_q   <= wb_req_idx;
            param_q <= wb_req_param;
            way_q   <= wb_req_way_en;
            vol_q   <= wb_req_voluntary;
            rc      <= 2'd0;
            wc      <= 2'd0;
            sc      <= 2'd0;
            wr_full <= 1'b0;
            state   <= READ;
          end
        end
        READ: begin
          if (data_req_fire && (rc == LAST_BEAT)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (release_fire && (sc == LAST_BEAT)) begin
`ifdef NBDCACHE_WB_RELEASE_ACK_EN
            state <= vol_q ? ACK_WAIT : IDLE;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef NBDCACHE_WB_RELEASE_ACK_EN
        ACK_WAIT: begin
          if (release_ack) begin
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbdcache_writeback_unit.sv
// Self-checking bench for nbdcache_writeback_unit. Expected read addresses
// and release beats are queued when a request is issued and checked as the
// DUT produces them. Honours NBDCACHE_WB_RELEASE_ACK_EN.
`timescale 1ns/1ps
module tb_nbdcache_writeback_unit;

  typedef struct {
    logic [7:0]  way;
    logic [11:0] addr;
  } rd_exp_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         last;
    logic [2:0]   param;
    logic         vol;
  } rel_exp_t;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         wb_req_valid = 1'b0;
  logic         wb_req_ready;
  logic [19:0]  wb_req_tag = '0;
  logic [5:0]   wb_req_idx = '0;
  logic [2:0]   wb_req_param = '0;
  logic [7:0]   wb_req_way_en = '0;
  logic         wb_req_voluntary = 1'b0;
  logic         data_req_valid;
  logic         data_req_ready = 1'b1;
  logic [7:0]   data_req_way_en;
  logic [11:0]  data_req_addr;
  logic [127:0] data_resp_data = '0;
  logic         release_valid;
  logic         release_ready = 1'b1;
  logic [31:0]  release_addr;
  logic [2:0]   release_param;
  logic         release_voluntary;
  logic [127:0] release_data;
  logic         release_last;
  logic         release_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  rd_exp_t  rd_q[$];
  rel_exp_t rel_q[$];
  int       rd_cyc[$];
  int       rel_cyc[$];
  int       rel_cnt = 0;
  int       stall_cnt = 0;
  logic     rdy_at_last = 1'b1;
  logic [31:0] cur_seed = '0;

  nbdcache_writeback_unit dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .wb_req_valid      (wb_req_valid),
    .wb_req_ready      (wb_req_ready),
    .wb_req_tag        (wb_req_tag),
    .wb_req_idx        (wb_req_idx),
    .wb_req_param      (wb_req_param),
    .wb_req_way_en     (wb_req_way_en),
    .wb_req_voluntary  (wb_req_voluntary),
    .data_req_valid    (data_req_valid),
    .data_req_ready    (data_req_ready),
    .data_req_way_en   (data_req_way_en),
    .data_req_addr     (data_req_addr),
    .data_resp_data    (data_resp_data),
    .release_valid     (release_valid),
    .release_ready     (release_ready),
    .release_addr      (release_addr),
    .release_param     (release_param),
    .release_voluntary (release_voluntary),
    .release_data      (release_data),
    .release_last      (release_last),
    .release_ack       (release_ack)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mkdata(input logic [31:0] seed, input int beat);
    return {seed, 64'h0, 32'(beat)};
  endfunction

  // Data-array model: returns the beat one cycle after each read handshake.
  int resp_beat = 0;
  logic resp_pend = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      resp_pend = 1'b0;
      data_resp_data = {4{32'hDEADBEEF}};
    end else begin
      if (resp_pend) data_resp_data = mkdata(cur_seed, resp_beat);
      else           data_resp_data = {4{32'hDEADBEEF}};
      resp_pend = data_req_valid && data_req_ready;
      resp_beat = int'(data_req_addr[5:4]);
    end
  end

  // Scoreboard and stall-stability monitor.
  logic         dstall = 1'b0, rstall = 1'b0;
  logic [11:0]  hold_daddr;
  logic [7:0]   hold_dway;
  logic [31:0]  hold_raddr;
  logic [127:0] hold_rdata;
  logic         hold_rlast;
  rd_exp_t      re;
  rel_exp_t     le;
  always @(negedge clock) begin
    if (!reset_n) begin
      dstall = 1'b0;
      rstall = 1'b0;
    end else begin
      if (dstall && data_req_valid) begin
        check("dreq_addr_hold", data_req_addr, hold_daddr);
        check("dreq_way_hold", data_req_way_en, hold_dway);
      end
      if (rstall && release_valid) begin
        check("rel_addr_hold", release_addr, hold_raddr);
        check("rel_data_hold", release_data, hold_rdata);
        check("rel_last_hold", release_last, hold_rlast);
      end
      dstall     = data_req_valid && !data_req_ready;
      hold_daddr = data_req_addr;
      hold_dway  = data_req_way_en;
      if (dstall) stall_cnt++;
      rstall     = release_valid && !release_ready;
      hold_raddr = release_addr;
      hold_rdata = release_data;
      hold_rlast = release_last;

      if (data_req_valid && data_req_ready) begin
        if (rd_q.size() == 0) check("dreq_stray", 1, 0);
        else begin
          re = rd_q.pop_front();
          check("dreq_addr", data_req_addr, re.addr);
          check("dreq_way", data_req_way_en, re.way);
        end
        rd_cyc.push_back(cyc);
      end

      if (release_valid && release_ready) begin
        if (rel_q.size() == 0) check("rel_stray", 1, 0);
        else begin
          le = rel_q.pop_front();
          check("rel_addr", release_addr, le.addr);
          check("rel_data", release_data, le.data);
          check("rel_last", release_last, le.last);
          check("rel_param", release_param, le.param);
          check("rel_vol", release_voluntary, le.vol);
          if (le.last) rdy_at_last = wb_req_ready;
        end
        rel_cyc.push_back(cyc);
        rel_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic send_req(input logic [19:0] tag, input logic [5:0] idx, input logic [2:0] prm,
                          input logic [7:0] way, input logic vol, input logic [31:0] seed);
    int bound;
    cur_seed = seed;
    for (int b = 0; b < 4; b++) begin
      rd_q.push_back('{way: way, addr: {idx, 2'(b), 4'h0}});
      rel_q.push_back('{addr: {tag, idx, 6'h0}, data: mkdata(seed, b), last: (b == 3),
                        param: prm, vol: vol});
    end
    wb_req_tag       = tag;
    wb_req_idx       = idx;
    wb_req_param     = prm;
    wb_req_way_en    = way;
    wb_req_voluntary = vol;
    wb_req_valid     = 1'b1;
    bound = 0;
    while (!wb_req_ready && bound < 20) begin
      tick(1);
      bound++;
    end
    if (!wb_req_ready) check("req_accept_timeout", 0, 1);
    tick(1);
    wb_req_valid = 1'b0;
  endtask

  task automatic wait_drained(input int bound);
    int n;
    n = 0;
    while (rel_q.size() != 0 && n < bound) begin
      tick(1);
      n++;
    end
    if (rel_q.size() != 0) check("drain_timeout", rel_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;

    // reset state
    tick(2);
    check("rst_wb_ready", wb_req_ready, 1);
    check("rst_dreq_valid", data_req_valid, 0);
    check("rst_rel_valid", release_valid, 0);
    check("rst_rel_last", release_last, 0);
    reset_n = 1'b1;
    tick(1);
    check("post_rst_ready", wb_req_ready, 1);

    // basic line, both readies high
    rd_cyc.delete();
    rel_cyc.delete();
    rdy_at_last = 1'b1;
    send_req(20'hABCDE, 6'h15, 3'h2, 8'h04, 1'b0, 32'h1111_0000);
    wait_drained(40);
    check("basic_ready_after", wb_req_ready, 1);
    check("basic_ready_at_last", rdy_at_last, 0);
    check("basic_rel_valid_after", release_valid, 0);
    check("basic_nreads", rd_cyc.size(), 4);
    if (rd_cyc.size() == 4) begin
      for (int i = 0; i < 3; i++) check("basic_read_gap", rd_cyc[i+1] - rd_cyc[i], 1);
      if (rel_cyc.size() > 0) check("basic_first_rel_lat", rel_cyc[0] - rd_cyc[0], 2);
    end

    // read stalls: data_req_ready toggling
    base = stall_cnt;
    send_req(20'h12345, 6'h2A, 3'h1, 8'h80, 1'b0, 32'h2222_0000);
    n = 0;
    while (rel_q.size() != 0 && n < 40) begin
      data_req_ready = ~data_req_ready;
      tick(1);
      n++;
    end
    data_req_ready = 1'b1;
    if (rel_q.size() != 0) check("stall_drain_timeout", rel_q.size(), 0);
    check("stall_seen", stall_cnt > base, 1);
    tick(1);

    // release backpressure for 6 cycles
    release_ready = 1'b0;
    send_req(20'h0F0F0, 6'h01, 3'h5, 8'h01, 1'b0, 32'h3333_0000);
    tick(4);
    check("bp_reads_done", data_req_valid, 0);
    check("bp_rel_valid", release_valid, 1);
    check("bp_rel_last", release_last, 0);
    check("bp_rel_beat0", release_data, mkdata(32'h3333_0000, 0));
    rel_cyc.delete();
    release_ready = 1'b1;
    wait_drained(20);
    check("bp_nbeats", rel_cyc.size(), 4);
    if (rel_cyc.size() == 4)
      for (int i = 0; i < 3; i++) check("bp_back_to_back", rel_cyc[i+1] - rel_cyc[i], 1);
    tick(1);

    // voluntary release; release_ack pulsed mid-line must be ignored
    send_req(20'h55AA5, 6'h3F, 3'h3, 8'h10, 1'b1, 32'h4444_0000);
    release_ack = 1'b1;
    tick(1);
    release_ack = 1'b0;
    wait_drained(40);
`ifdef NBDCACHE_WB_RELEASE_ACK_EN
    check("ack_wait_ready0", wb_req_ready, 0);
    tick(3);
    check("ack_wait_hold", wb_req_ready, 0);
    check("ack_wait_rel_valid", release_valid, 0);
    release_ack = 1'b1;
    tick(1);
    release_ack = 1'b0;
    check("ack_done_ready", wb_req_ready, 1);
`else
    check("vol_ready_after", wb_req_ready, 1);
`endif
    tick(1);

    // asynchronous reset after beat 1 has been sent
    base = rel_cnt;
    send_req(20'h00ABC, 6'h07, 3'h4, 8'h02, 1'b0, 32'h5555_0000);
    n = 0;
    while (rel_cnt < base + 2 && n < 20) begin
      tick(1);
      n++;
    end
    check("rst_mid_two_beats", rel_cnt, base + 2);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_dreq_valid", data_req_valid, 0);
    check("rst_mid_rel_valid", release_valid, 0);
    check("rst_mid_rel_last", release_last, 0);
    check("rst_mid_ready", wb_req_ready, 1);
    rd_q.delete();
    rel_q.delete();
    base = rel_cnt;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("rst_rel_ready", wb_req_ready, 1);
    tick(10);
    check("rst_no_stray", rel_cnt, base);
    check("rst_idle_rel_valid", release_valid, 0);

    // recovery line after reset
    send_req(20'hFEDCB, 6'h2C, 3'h6, 8'h40, 1'b0, 32'h6666_0000);
    wait_drained(40);
    check("recover_ready", wb_req_ready, 1);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
